// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: ALU function codes, opcode and
// funct values, control FSM states and datapath mux select encodings.
package mips_pkg;

  localparam logic [3:0] ALU_PASSB = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_SUB   = 4'd2;
  localparam logic [3:0] ALU_ADD   = 4'd3;
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_NOR   = 4'd6;
  localparam logic [3:0] ALU_SLT   = 4'd7;
  localparam logic [3:0] ALU_SLTU  = 4'd8;
  localparam logic [3:0] ALU_PASSA = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPE,
    S_ITYPE,
    S_ALUWB,
    S_BRANCH,
    S_JUMP
  } state_e;

  localparam logic       SRCA_PC      = 1'b0;
  localparam logic       SRCA_A       = 1'b1;
  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_4       = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  function automatic logic funct_legal(input logic [5:0] f);
    return (f[5:3] == 3'b100) || (f == FN_SLT) || (f == FN_SLTU);
  endfunction

  // addi..lui occupy the contiguous opcode range 08h-0Fh
  function automatic logic is_itype(input logic [5:0] o);
    return o[5:3] == 3'b001;
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU function and immediate-extension decode for the multicycle control FSM.
// Purely combinational from the current state and the instruction fields.
module mc_alu_dec
  import mips_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_f_o,
  output logic [1:0] ext_op_o
);

  always_comb begin
    alu_f_o  = ALU_ADD;
    ext_op_o = EXT_ZERO;
    case (state_i)
      S_DECODE, S_MEMADR: ext_op_o = EXT_SIGN;
      S_RTYPE: begin
        case (funct_i)
          FN_ADD, FN_ADDU: alu_f_o = ALU_ADD;
          FN_SUB, FN_SUBU: alu_f_o = ALU_SUB;
          FN_AND:          alu_f_o = ALU_AND;
          FN_OR:           alu_f_o = ALU_OR;
          FN_XOR:          alu_f_o = ALU_XOR;
          FN_NOR:          alu_f_o = ALU_NOR;
          FN_SLT:          alu_f_o = ALU_SLT;
          FN_SLTU:         alu_f_o = ALU_SLTU;
          default:         alu_f_o = ALU_ADD;
        endcase
      end
      S_ITYPE: begin
        ext_op_o = EXT_SIGN;
        case (op_i)
          OP_ADDI, OP_ADDIU: alu_f_o = ALU_ADD;
          OP_SLTI:           alu_f_o = ALU_SLT;
          OP_SLTIU:          alu_f_o = ALU_SLTU;
          OP_ANDI: begin
            alu_f_o  = ALU_AND;
            ext_op_o = EXT_ZERO;
          end
          OP_ORI: begin
            alu_f_o  = ALU_OR;
            ext_op_o = EXT_ZERO;
          end
          OP_XORI: begin
            alu_f_o  = ALU_XOR;
            ext_op_o = EXT_ZERO;
          end
          OP_LUI: begin
            alu_f_o  = ALU_PASSB;
            ext_op_o = EXT_LUI;
          end
          default: alu_f_o = ALU_ADD;
        endcase
      end
      S_BRANCH: alu_f_o = ALU_SUB;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control unit: Moore FSM driving datapath selects and enables,
// handshaking with memory via mem_ready and aborting stalled accesses after MEM_TO cycles.
module mc_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TO = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem2reg,
  output logic       srca,
  output logic [1:0] srcb,
  output logic [1:0] ext_op,
  output logic [3:0] alu_f,
  output logic       illegal,
  output logic       mem_err
);

  localparam int unsigned CW    = (MEM_TO < 2) ? 1 : $clog2(MEM_TO + 1);
  localparam bit          TO_EN = (MEM_TO != 0);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_mem, timeout;
  logic [3:0]      alu_f_dec;
  logic [1:0]      ext_op_dec;

  mc_alu_dec u_alu_dec (
    .state_i (state_q),
    .op_i    (op),
    .funct_i (funct),
    .alu_f_o (alu_f_dec),
    .ext_op_o(ext_op_dec)
  );

  assign in_mem  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout = TO_EN && in_mem && !mem_ready && (cnt_q == CW'(MEM_TO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A timeout in FETCH keeps the state, so the counter must clear on it explicitly
  always_comb begin
    cnt_d = cnt_q;
    if (timeout || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (TO_EN && in_mem && !mem_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    mem_rd  = 1'b0;
    mem_we  = 1'b0;
    iord    = 1'b0;
    ir_we   = 1'b0;
    pc_en   = 1'b0;
    pc_src  = PC_ALU;
    reg_we  = 1'b0;
    reg_dst = 1'b0;
    mem2reg = 1'b0;
    srca    = SRCA_PC;
    srcb    = SRCB_B;
    illegal = 1'b0;
    mem_err = 1'b0;

    case (state_q)
      S_FETCH: begin
        srcb = SRCB_4;
        if (timeout) begin
          mem_err = 1'b1;
        end else begin
          mem_rd = 1'b1;
          ir_we  = mem_ready;
          pc_en  = mem_ready;
          if (mem_ready) state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        srcb = SRCB_IMM_SH2;
        if ((op == OP_LW) || (op == OP_SW))                state_d = S_MEMADR;
        else if ((op == OP_RTYPE) && funct_legal(funct))   state_d = S_RTYPE;
        else if (is_itype(op))                             state_d = S_ITYPE;
        else if ((op == OP_BEQ) || (op == OP_BNE))         state_d = S_BRANCH;
        else if (op == OP_J)                               state_d = S_JUMP;
        else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMADR: begin
        srca    = SRCA_A;
        srcb    = SRCB_IMM;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (timeout) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          mem_rd = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        reg_we  = 1'b1;
        mem2reg = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        iord = 1'b1;
        if (timeout) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          mem_we = 1'b1;
          if (mem_ready) state_d = S_FETCH;
        end
      end
      S_RTYPE: begin
        srca    = SRCA_A;
        reg_dst = 1'b1;
        state_d = S_ALUWB;
      end
      S_ITYPE: begin
        srca    = SRCA_A;
        srcb    = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        reg_dst = (op == OP_RTYPE);
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        srca    = SRCA_A;
        pc_src  = PC_ALUOUT;
        pc_en   = zero ^ (op == OP_BNE);
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = PC_JUMP;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // The register only clears on the reset edge; hold every output quiet for the whole low phase
    if (!rst_n) begin
      mem_rd  = 1'b0;
      mem_we  = 1'b0;
      iord    = 1'b0;
      ir_we   = 1'b0;
      pc_en   = 1'b0;
      pc_src  = PC_ALU;
      reg_we  = 1'b0;
      reg_dst = 1'b0;
      mem2reg = 1'b0;
      srca    = SRCA_PC;
      srcb    = SRCB_B;
      illegal = 1'b0;
      mem_err = 1'b0;
    end
  end

  assign alu_f  = rst_n ? alu_f_dec  : ALU_ADD;
  assign ext_op = rst_n ? ext_op_dec : EXT_ZERO;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: two instances (MEM_TO=255 and MEM_TO=3) sharing stimulus, one selected at a time,
// compared each cycle against an instruction-level model of the control sequence.
module tb_mc_ctrl;

  typedef struct packed {
    logic       mem_rd, mem_we, iord, ir_we, pc_en;
    logic [1:0] pc_src;
    logic       reg_we, reg_dst, mem2reg, srca;
    logic [1:0] srcb, ext_op;
    logic [3:0] alu_f;
    logic       illegal, mem_err;
  } ov_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       sel;
  int         mto;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic       mem_rd0, mem_we0, iord0, ir_we0, pc_en0, reg_we0, reg_dst0, mem2reg0, srca0, illegal0, mem_err0;
  logic [1:0] pc_src0, srcb0, ext_op0;
  logic [3:0] alu_f0;
  logic       mem_rd3, mem_we3, iord3, ir_we3, pc_en3, reg_we3, reg_dst3, mem2reg3, srca3, illegal3, mem_err3;
  logic [1:0] pc_src3, srcb3, ext_op3;
  logic [3:0] alu_f3;
  logic [20:0] obs0, obs3, obs;

  always #5 clk = ~clk;

  mc_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_rd(mem_rd0), .mem_we(mem_we0), .iord(iord0), .ir_we(ir_we0), .pc_en(pc_en0),
    .pc_src(pc_src0), .reg_we(reg_we0), .reg_dst(reg_dst0), .mem2reg(mem2reg0), .srca(srca0),
    .srcb(srcb0), .ext_op(ext_op0), .alu_f(alu_f0), .illegal(illegal0), .mem_err(mem_err0)
  );

  mc_ctrl #(.MEM_TO(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_rd(mem_rd3), .mem_we(mem_we3), .iord(iord3), .ir_we(ir_we3), .pc_en(pc_en3),
    .pc_src(pc_src3), .reg_we(reg_we3), .reg_dst(reg_dst3), .mem2reg(mem2reg3), .srca(srca3),
    .srcb(srcb3), .ext_op(ext_op3), .alu_f(alu_f3), .illegal(illegal3), .mem_err(mem_err3)
  );

  assign obs0 = {mem_rd0, mem_we0, iord0, ir_we0, pc_en0, pc_src0, reg_we0, reg_dst0, mem2reg0,
                 srca0, srcb0, ext_op0, alu_f0, illegal0, mem_err0};
  assign obs3 = {mem_rd3, mem_we3, iord3, ir_we3, pc_en3, pc_src3, reg_we3, reg_dst3, mem2reg3,
                 srca3, srcb3, ext_op3, alu_f3, illegal3, mem_err3};
  assign obs  = sel ? obs3 : obs0;

  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ov_t idle();
    ov_t e = '0;
    e.alu_f = 4'd3;
    return e;
  endfunction

  // Caller has driven this cycle's inputs just after the rising edge
  task automatic step(input string tag, input ov_t e);
    @(negedge clk);
    check(tag, obs, e);
    @(posedge clk);
    #1;
  endtask

  function automatic int rfn(input logic [5:0] f);
    case (f)
      6'h20, 6'h21: return 3;
      6'h22, 6'h23: return 2;
      6'h24:        return 4;
      6'h25:        return 1;
      6'h26:        return 5;
      6'h27:        return 6;
      6'h2A:        return 7;
      6'h2B:        return 8;
      default:      return -1;
    endcase
  endfunction

  function automatic void iinfo(input logic [5:0] o, output logic [3:0] a, output logic [1:0] x);
    a = 4'd3;
    x = 2'd1;
    case (o)
      6'h0A: a = 4'd7;
      6'h0B: a = 4'd8;
      6'h0C: begin a = 4'd4; x = 2'd0; end
      6'h0D: begin a = 4'd1; x = 2'd0; end
      6'h0E: begin a = 4'd5; x = 2'd0; end
      6'h0F: begin a = 4'd0; x = 2'd2; end
      default: ;
    endcase
  endfunction

  // 0 illegal, 1 lw, 2 sw, 3 R-type, 4 I-type, 5 branch, 6 jump
  function automatic int cls_of(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h23) return 1;
    if (o == 6'h2B) return 2;
    if (o == 6'h00) return (rfn(f) >= 0) ? 3 : 0;
    if (o >= 6'h08 && o <= 6'h0F) return 4;
    if (o == 6'h04 || o == 6'h05) return 5;
    if (o == 6'h02) return 6;
    return 0;
  endfunction

  // A memory wait of w cycles: ready low for w cycles then high, unless the timeout fires first
  task automatic mem_phase(input string tag, input ov_t wait_e, input ov_t rdy_e, input int w,
                           output bit ok);
    ov_t e;
    ok = 1'b0;
    for (int k = 0; k <= w; k++) begin
      zero = 1'($urandom);
      if (k == w) begin
        mem_ready = 1'b1;
        step(tag, rdy_e);
        ok = 1'b1;
        return;
      end
      mem_ready = 1'b0;
      if (mto != 0 && k == mto) begin
        e = wait_e;
        e.mem_rd  = 1'b0;
        e.mem_we  = 1'b0;
        e.mem_err = 1'b1;
        step({tag, "_timeout"}, e);
        return;
      end
      step(tag, wait_e);
    end
  endtask

  task automatic noise();
    mem_ready = 1'($urandom);
    zero      = 1'($urandom);
  endtask

  task automatic run_insn(input logic [5:0] o, input logic [5:0] f, input logic z,
                          input int wf, input int wm);
    ov_t   e, ew;
    bit    ok;
    int    c;
    string t;
    logic [3:0] ia;
    logic [1:0] ix;
    op = o;
    funct = f;
    c = cls_of(o, f);
    t = $sformatf("op%h_fn%h", o, f);
    ew = idle();
    ew.mem_rd = 1'b1;
    ew.srcb   = 2'd1;
    e = ew;
    e.ir_we = 1'b1;
    e.pc_en = 1'b1;
    mem_phase({t, "_fetch"}, ew, e, wf, ok);
    if (!ok) mem_phase({t, "_refetch"}, ew, e, 0, ok);
    noise();
    e = idle();
    e.srcb    = 2'd3;
    e.ext_op  = 2'd1;
    e.illegal = (c == 0);
    step({t, "_decode"}, e);
    noise();
    case (c)
      1, 2: begin
        e = idle();
        e.srca = 1'b1; e.srcb = 2'd2; e.ext_op = 2'd1;
        step({t, "_memadr"}, e);
        e = idle();
        e.iord = 1'b1;
        if (c == 1) e.mem_rd = 1'b1;
        else        e.mem_we = 1'b1;
        mem_phase({t, "_mem"}, e, e, wm, ok);
        if (ok && c == 1) begin
          noise();
          e = idle();
          e.reg_we = 1'b1; e.mem2reg = 1'b1;
          step({t, "_memwb"}, e);
        end
      end
      3, 4: begin
        e = idle();
        e.srca = 1'b1;
        if (c == 3) begin
          e.alu_f   = 4'(rfn(f));
          e.reg_dst = 1'b1;
        end else begin
          iinfo(o, ia, ix);
          e.srcb = 2'd2; e.alu_f = ia; e.ext_op = ix;
        end
        step({t, "_exec"}, e);
        noise();
        e = idle();
        e.reg_we  = 1'b1;
        e.reg_dst = (c == 3);
        step({t, "_aluwb"}, e);
      end
      5: begin
        zero = z;
        e = idle();
        e.srca = 1'b1; e.alu_f = 4'd2; e.pc_src = 2'd1;
        e.pc_en = z ^ (o == 6'h05);
        step({t, "_branch"}, e);
      end
      6: begin
        e = idle();
        e.pc_src = 2'd2; e.pc_en = 1'b1;
        step({t, "_jump"}, e);
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) step("reset", idle());
    rst_n = 1'b1;
  endtask

  task automatic rand_insn(input int maxw);
    logic [5:0] pool [20] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                              6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h23, 6'h2B, 6'h2B, 6'h3F, 6'h01};
    logic [5:0] legal [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [5:0] o, f;
    int wf, wm;
    o  = ($urandom_range(9) == 0) ? 6'($urandom) : pool[$urandom_range(19)];
    f  = ($urandom_range(3) == 0) ? 6'($urandom) : legal[$urandom_range(9)];
    wf = ($urandom_range(3) == 0) ? $urandom_range(maxw) : 0;
    wm = ($urandom_range(2) == 0) ? $urandom_range(maxw) : 0;
    run_insn(o, f, 1'($urandom), wf, wm);
  endtask

  initial begin
    rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    sel = 1'b0; mto = 255;
    @(posedge clk);
    #1;
    do_reset();
    run_insn(6'h23, 6'h00, 1'b0, 0, 0);
    run_insn(6'h00, 6'h2A, 1'b0, 0, 0);
    run_insn(6'h0D, 6'h11, 1'b0, 0, 0);
    run_insn(6'h04, 6'h00, 1'b1, 0, 0);
    run_insn(6'h05, 6'h00, 1'b1, 0, 0);
    run_insn(6'h2B, 6'h00, 1'b0, 0, 4);
    run_insn(6'h3F, 6'h00, 1'b0, 0, 0);
    run_insn(6'h00, 6'h00, 1'b0, 0, 0);
    run_insn(6'h0F, 6'h00, 1'b0, 2, 2);
    run_insn(6'h02, 6'h00, 1'b0, 0, 0);

    // reset asserted mid-lw, while in the address phase
    op = 6'h23;
    mem_ready = 1'b1;
    step("abort_fetch", '{mem_rd: 1'b1, ir_we: 1'b1, pc_en: 1'b1, srcb: 2'd1, alu_f: 4'd3, default: '0});
    step("abort_decode", '{srcb: 2'd3, ext_op: 2'd1, alu_f: 4'd3, default: '0});
    rst_n = 1'b0;
    step("abort_rst", idle());
    rst_n = 1'b1;
    run_insn(6'h09, 6'h00, 1'b0, 0, 0);

    for (int i = 0; i < 60; i++) rand_insn(2);

    sel = 1'b1;
    mto = 3;
    do_reset();
    run_insn(6'h2B, 6'h00, 1'b0, 0, 4);
    run_insn(6'h23, 6'h00, 1'b0, 5, 0);
    run_insn(6'h23, 6'h00, 1'b0, 0, 3);
    run_insn(6'h23, 6'h00, 1'b0, 0, 2);
    run_insn(6'h2B, 6'h00, 1'b0, 3, 3);
    for (int i = 0; i < 60; i++) rand_insn(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
